// File: rtl/sdpram_sc_ctrl_if.sv
// Bus bundle for sdpram_sc_ctrl: write port, read port and clear control.
// master = the side that issues writes, reads and clears; slave = the RAM.
interface sdpram_sc_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 71,
  parameter int unsigned ADDR_WIDTH = 8
) ();
  localparam int unsigned BE_WIDTH = (DATA_WIDTH + 7) / 8;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_byte_en;
  logic                  wr_perr_inj;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_perr;
  logic                  clr_req;
  logic                  init_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_byte_en, wr_perr_inj,
    output rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, rd_perr, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_byte_en, wr_perr_inj,
    input  rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, rd_perr, init_done
  );
endinterface

// File: rtl/sdpram_sc_ctrl.sv
// Single-clock simple dual-port RAM with byte enables, write-first bypass and a clear sequencer.
// Optional per-lane even parity is enabled by defining SDPRAM_PARITY_EN.
module sdpram_sc_ctrl #(
  parameter int unsigned DATA_WIDTH     = 71,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned OUTPUT_REG     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  sdpram_sc_ctrl_if.slave bus
);
  localparam int unsigned BE_WIDTH = (DATA_WIDTH + 7) / 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  init_done_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  collide;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_perr_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  s1_valid;
  logic                  s1_perr;
  logic [DATA_WIDTH-1:0] s1_data;

  assign wr_acc  = bus.wr_en & (state == IDLE);
  assign rd_acc  = bus.rd_en & (state == IDLE);
  assign collide = wr_acc & rd_acc & (bus.wr_addr == bus.rd_addr);

  always_comb begin
    lane_mask = '0;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      lane_mask[b] = bus.wr_byte_en[b / 8];
    end
  end

  // Write-first: enabled lanes come from the incoming write, the rest from the array.
  assign rd_word = collide ? ((mem[bus.rd_addr] & ~lane_mask) | (bus.wr_data & lane_mask))
                           : mem[bus.rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr    <= '0;
      init_done_q <= (CLEAR_ON_RESET == 0);
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (clr_addr == '1) begin
        state       <= IDLE;
        init_done_q <= 1'b1;
      end
    end else if (bus.clr_req) begin
      state       <= CLEAR;
      clr_addr    <= '0;
      init_done_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr] <= (mem[bus.wr_addr] & ~lane_mask) | (bus.wr_data & lane_mask);
    end
  end

`ifdef SDPRAM_PARITY_EN
  logic [BE_WIDTH-1:0] par_mem [DEPTH];
  logic [BE_WIDTH-1:0] wr_par;
  logic [BE_WIDTH-1:0] chk_par;
  logic [BE_WIDTH-1:0] rd_par;

  always_comb begin
    wr_par  = '0;
    chk_par = '0;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      wr_par[b / 8]  = wr_par[b / 8] ^ bus.wr_data[b];
      chk_par[b / 8] = chk_par[b / 8] ^ rd_word[b];
    end
    wr_par[0] = wr_par[0] ^ bus.wr_perr_inj;
  end

  assign rd_par = collide ? ((par_mem[bus.rd_addr] & ~bus.wr_byte_en) | (wr_par & bus.wr_byte_en))
                          : par_mem[bus.rd_addr];
  assign rd_perr_next = |(chk_par ^ rd_par);

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par_mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      par_mem[bus.wr_addr] <= (par_mem[bus.wr_addr] & ~bus.wr_byte_en) | (wr_par & bus.wr_byte_en);
    end
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = bus.wr_perr_inj;
  assign rd_perr_next    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_perr  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      s1_perr  <= rd_acc & rd_perr_next;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  s2_valid;
    logic                  s2_perr;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_perr  <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_perr  <= s1_perr;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign bus.rd_data  = s2_data;
    assign bus.rd_valid = s2_valid;
    assign bus.rd_perr  = s2_perr;
  end else begin : g_noreg
    assign bus.rd_data  = s1_data;
    assign bus.rd_valid = s1_valid;
    assign bus.rd_perr  = s1_perr;
  end

  assign bus.init_done = init_done_q;
endmodule
